// File: rtl/uart_pkg.sv
// Shared definitions for the 16550 data buffers: trigger-level encoding and
// the helper that turns a trigger level into an occupancy threshold.
package uart_pkg;

   typedef enum logic [1:0] {
      TRIG_1  = 2'b00,   // one entry
      TRIG_Q  = 2'b01,   // quarter full
      TRIG_H  = 2'b10,   // half full
      TRIG_NF = 2'b11    // nearly full (two short of DEPTH)
   } trig_lvl_e;

   // Occupancy at which trig_hit asserts for a given level and FIFO depth.
   function automatic int unsigned trig_threshold(input trig_lvl_e lvl,
                                                  input int unsigned depth);
      int unsigned thr;
      case (lvl)
         TRIG_1:  thr = 1;
         TRIG_Q:  thr = depth / 4;
         TRIG_H:  thr = depth / 2;
         default: thr = depth - 2;
      endcase
      return thr;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the UART FIFO: synchronous write, registered
// synchronous read. The read register holds its value when no read is issued.
module fifo_mem #(
   parameter  int WIDTH      = 11,
   parameter  int DEPTH      = 16,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port.
   // NOTE: the array carries no reset; occupancy tracking in the parent keeps
   // unwritten locations from ever being read, and a reset would block RAM mapping.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port; resets to zero so rd_data has a defined value.
   // NOTE: non-blocking assignment means a read and write to the same address
   // in one cycle return the old contents, which the full-FIFO push+pop relies on.
   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/uart_fifo.sv
// 16550 RX/TX data buffer: data + error tag per entry, occupancy count,
// synchronous flush, programmable trigger, sticky overrun, error-in-FIFO flag.
module uart_fifo
   import uart_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  int ERR_WIDTH  = 3,
   parameter  int DEPTH      = 16,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [ERR_WIDTH-1:0]  wr_err,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic [ERR_WIDTH-1:0]  rd_err,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   count,
   input  logic [1:0]            trig_lvl,
   output logic                  trig_hit,
   output logic                  overrun,
   input  logic                  ovr_clr,
   output logic                  err_in_fifo
);

   localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

   logic [ADDR_WIDTH-1:0]       wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]         err_cnt;
   logic [DEPTH-1:0]            err_map;     // per-slot "tag is non-zero" flag
   logic                        pop_ok, push_ok, drop;
   logic                        push_err, pop_err;
   logic [ADDR_WIDTH:0]         count_next, err_next;
   int unsigned                 thresh;
   logic [WIDTH+ERR_WIDTH-1:0]  mem_rd;

   // Flags decoded purely from registered state.
   assign empty       = (count == '0);
   assign full        = (count == FULL_CNT);
   assign err_in_fifo = (err_cnt != '0);
   assign rd_data     = mem_rd[WIDTH-1:0];
   assign rd_err      = mem_rd[WIDTH +: ERR_WIDTH];

   // Handshake decode and next-state arithmetic; flush overrides push and pop.
   // NOTE: every signal gets a default before any branch so no latch is inferred.
   always_comb begin
      pop_ok     = rd_en && !empty && !clr;
      push_ok    = wr_en && (!full || (rd_en && !empty)) && !clr;
      drop       = wr_en && full && !rd_en && !clr;
      push_err   = push_ok && (wr_err != '0);
      pop_err    = pop_ok && err_map[rd_ptr];
      count_next = count;
      err_next   = err_cnt;
      if (clr) begin
         count_next = '0;
         err_next   = '0;
      end else begin
         if (push_ok && !pop_ok)      count_next = count + 1'b1;
         else if (pop_ok && !push_ok) count_next = count - 1'b1;
         if (push_err && !pop_err)      err_next = err_cnt + 1'b1;
         else if (pop_err && !push_err) err_next = err_cnt - 1'b1;
      end
      thresh = trig_threshold(trig_lvl_e'(trig_lvl), DEPTH);
   end

   // Pointers, counters, read strobe, trigger and overrun state.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         err_cnt  <= '0;
         rd_valid <= 1'b0;
         trig_hit <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         end
         count    <= count_next;
         err_cnt  <= err_next;
         rd_valid <= pop_ok;
         trig_hit <= (32'(count_next) >= thresh);
         if (drop)         overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;
      end
   end

   // Side map of non-zero tags so a pop can update err_cnt in the same cycle.
   always_ff @(posedge clk) begin
      if (rst)          err_map <= '0;
      else if (push_ok) err_map[wr_ptr] <= (wr_err != '0);
   end

   fifo_mem #(
      .WIDTH (WIDTH + ERR_WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr),
      .wr_data ({wr_err, wr_data}),
      .rd_en   (pop_ok),
      .rd_addr (rd_ptr),
      .rd_data (mem_rd)
   );

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: a table of directed vectors, hand-written full/flush/reset
// sequences, then randomized traffic checked against a queue-based model.
module tb_uart_fifo;

   localparam int WIDTH     = 8;
   localparam int ERR_WIDTH = 3;
   localparam int DEPTH     = 16;

   logic       clk = 1'b0;
   logic       rst, clr, wr_en, rd_en, ovr_clr;
   logic [7:0] wr_data;
   logic [2:0] wr_err;
   logic [1:0] trig_lvl;
   logic [7:0] rd_data;
   logic [2:0] rd_err;
   logic       rd_valid, empty, full, trig_hit, overrun, err_in_fifo;
   logic [4:0] count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_fifo #(.WIDTH(WIDTH), .ERR_WIDTH(ERR_WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
      .wr_err(wr_err), .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
      .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
      .trig_lvl(trig_lvl), .trig_hit(trig_hit), .overrun(overrun),
      .ovr_clr(ovr_clr), .err_in_fifo(err_in_fifo)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model: a queue of {tag, data} ----------------
   logic [10:0] mq[$];
   logic [7:0]  m_rd_data;
   logic [2:0]  m_rd_err;
   logic        m_rv, m_ovr, m_trig;

   function automatic int thr(input logic [1:0] t);
      case (t)
         2'd0:    return 1;
         2'd1:    return DEPTH / 4;
         2'd2:    return DEPTH / 2;
         default: return DEPTH - 2;
      endcase
   endfunction

   function automatic bit model_eif();
      foreach (mq[i]) if (mq[i][10:8] != 3'd0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step();
      int sz;
      bit pop, push;
      if (rst) begin
         mq.delete();
         m_rd_data = '0; m_rd_err = '0; m_rv = 1'b0; m_ovr = 1'b0;
      end else if (clr) begin
         mq.delete();
         m_rv = 1'b0;
         if (ovr_clr) m_ovr = 1'b0;
      end else begin
         sz   = mq.size();
         pop  = rd_en && sz > 0;
         push = wr_en && (sz < DEPTH || pop);
         m_rv = pop;
         if (pop) {m_rd_err, m_rd_data} = mq.pop_front();
         if (push) mq.push_back({wr_err, wr_data});
         if (wr_en && !push) m_ovr = 1'b1;
         else if (ovr_clr)   m_ovr = 1'b0;
      end
      m_trig = !rst && (mq.size() >= thr(trig_lvl));
   endtask

   // Drive one cycle of inputs, clock it, advance the model, settle.
   task automatic apply(input logic r, input logic c, input logic we, input logic [7:0] wd,
                        input logic [2:0] werr, input logic re, input logic oc,
                        input logic [1:0] t);
      rst = r; clr = c; wr_en = we; wr_data = wd; wr_err = werr;
      rd_en = re; ovr_clr = oc; trig_lvl = t;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic [2:0] e);
      apply(0, 0, 1, d, e, 0, 0, 2'd1);
   endtask

   task automatic pop();
      apply(0, 0, 0, 8'h00, 3'd0, 1, 0, 2'd1);
   endtask

   task automatic check_model(input int cyc);
      check($sformatf("rnd%0d.count", cyc), count, mq.size());
      check($sformatf("rnd%0d.empty", cyc), empty, mq.size() == 0);
      check($sformatf("rnd%0d.full", cyc), full, mq.size() == DEPTH);
      check($sformatf("rnd%0d.rd_valid", cyc), rd_valid, m_rv);
      check($sformatf("rnd%0d.rd_data", cyc), rd_data, m_rd_data);
      check($sformatf("rnd%0d.rd_err", cyc), rd_err, m_rd_err);
      check($sformatf("rnd%0d.trig_hit", cyc), trig_hit, m_trig);
      check($sformatf("rnd%0d.overrun", cyc), overrun, m_ovr);
      check($sformatf("rnd%0d.err_in_fifo", cyc), err_in_fifo, model_eif());
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       r, c, we;
      logic [7:0] wd;
      logic [2:0] werr;
      logic       re, oc;
      logic [1:0] t;
      int         cnt;
      logic       rv;
      logic [7:0] rdat;
      logic [2:0] rerr;
      logic       trg, eif, ovr;
   } vec_t;

   function automatic vec_t mk(input logic r, c, we, input logic [7:0] wd, input logic [2:0] werr,
                               input logic re, oc, input logic [1:0] t, input int cnt,
                               input logic rv, input logic [7:0] rdat, input logic [2:0] rerr,
                               input logic trg, eif, ovr);
      vec_t v;
      v.r = r; v.c = c; v.we = we; v.wd = wd; v.werr = werr; v.re = re; v.oc = oc; v.t = t;
      v.cnt = cnt; v.rv = rv; v.rdat = rdat; v.rerr = rerr; v.trg = trg; v.eif = eif; v.ovr = ovr;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      //        r  c  we wd     werr re oc t  | cnt rv rdat   rerr trg eif ovr
      tbl.push_back(mk(1, 0, 0, 8'h00, 3'd0, 0, 0, 2'd1, 0, 0, 8'h00, 3'd0, 0, 0, 0)); // reset
      tbl.push_back(mk(0, 0, 1, 8'h41, 3'd0, 0, 0, 2'd1, 1, 0, 8'h00, 3'd0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 8'h42, 3'd0, 0, 0, 2'd1, 2, 0, 8'h00, 3'd0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 8'h43, 3'd0, 0, 0, 2'd1, 3, 0, 8'h00, 3'd0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 8'h44, 3'd0, 0, 0, 2'd1, 4, 0, 8'h00, 3'd0, 1, 0, 0)); // TRIG_Q hit
      tbl.push_back(mk(0, 0, 0, 8'h00, 3'd0, 1, 0, 2'd1, 3, 1, 8'h41, 3'd0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 3'd0, 1, 0, 2'd1, 2, 1, 8'h42, 3'd0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 3'd0, 1, 0, 2'd1, 1, 1, 8'h43, 3'd0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 3'd0, 1, 0, 2'd1, 0, 1, 8'h44, 3'd0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 3'd0, 1, 0, 2'd1, 0, 0, 8'h44, 3'd0, 0, 0, 0)); // pop on empty
      tbl.push_back(mk(0, 0, 1, 8'h55, 3'd0, 1, 0, 2'd1, 1, 0, 8'h44, 3'd0, 0, 0, 0)); // no bypass
      tbl.push_back(mk(0, 0, 0, 8'h00, 3'd0, 1, 0, 2'd1, 0, 1, 8'h55, 3'd0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 8'h10, 3'd0, 0, 0, 2'd1, 1, 0, 8'h55, 3'd0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 8'h20, 3'd2, 0, 0, 2'd1, 2, 0, 8'h55, 3'd0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 8'h30, 3'd0, 0, 0, 2'd1, 3, 0, 8'h55, 3'd0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 3'd0, 1, 0, 2'd1, 2, 1, 8'h10, 3'd0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 3'd0, 1, 0, 2'd1, 1, 1, 8'h20, 3'd2, 0, 0, 0)); // tagged pop
      tbl.push_back(mk(0, 0, 0, 8'h00, 3'd0, 1, 0, 2'd0, 0, 1, 8'h30, 3'd0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 8'h77, 3'd0, 0, 0, 2'd0, 1, 0, 8'h30, 3'd0, 1, 0, 0)); // TRIG_1 hit
      tbl.push_back(mk(0, 0, 0, 8'h00, 3'd0, 0, 0, 2'd3, 1, 0, 8'h30, 3'd0, 0, 0, 0)); // level change
      tbl.push_back(mk(0, 0, 0, 8'h00, 3'd0, 1, 0, 2'd2, 0, 1, 8'h77, 3'd0, 0, 0, 0));
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] exp_d;
      bit hi_wr;
      rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
      wr_data = '0; wr_err = '0; trig_lvl = 2'd1;
      repeat (2) @(posedge clk);
      #1;

      // Table-driven vectors.
      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].c, tbl[i].we, tbl[i].wd, tbl[i].werr, tbl[i].re, tbl[i].oc, tbl[i].t);
         check($sformatf("row%0d.count", i), count, tbl[i].cnt);
         check($sformatf("row%0d.empty", i), empty, tbl[i].cnt == 0);
         check($sformatf("row%0d.full", i), full, tbl[i].cnt == DEPTH);
         check($sformatf("row%0d.rd_valid", i), rd_valid, tbl[i].rv);
         check($sformatf("row%0d.rd_data", i), rd_data, tbl[i].rdat);
         check($sformatf("row%0d.rd_err", i), rd_err, tbl[i].rerr);
         check($sformatf("row%0d.trig_hit", i), trig_hit, tbl[i].trg);
         check($sformatf("row%0d.overrun", i), overrun, tbl[i].ovr);
         check($sformatf("row%0d.err_in_fifo", i), err_in_fifo, tbl[i].eif);
      end

      // Fill, overflow, overrun clear, set-wins, full push+pop with wrap.
      apply(1, 0, 0, 8'h00, 3'd0, 0, 0, 2'd1);
      for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i), 3'd0);
      check("fill.count", count, 16);
      check("fill.full", full, 1);
      check("fill.trig_hit", trig_hit, 1);
      push(8'h99, 3'd0);
      check("drop.count", count, 16);
      check("drop.overrun", overrun, 1);
      apply(0, 0, 0, 8'h00, 3'd0, 0, 1, 2'd1);
      check("ovr_clr.overrun", overrun, 0);
      apply(0, 0, 1, 8'h99, 3'd0, 0, 1, 2'd1);
      check("set_wins.overrun", overrun, 1);
      apply(0, 0, 0, 8'h00, 3'd0, 0, 1, 2'd1);
      check("ovr_clr2.overrun", overrun, 0);
      apply(0, 0, 1, 8'hAA, 3'd0, 1, 0, 2'd1);
      check("full_pp.count", count, 16);
      check("full_pp.rd_valid", rd_valid, 1);
      check("full_pp.rd_data", rd_data, 8'h80);
      for (int i = 1; i <= DEPTH; i++) begin
         pop();
         exp_d = (i < DEPTH) ? 8'h80 + 8'(i) : 8'hAA;
         check($sformatf("drain%0d.rd_data", i), rd_data, exp_d);
         check($sformatf("drain%0d.rd_valid", i), rd_valid, 1);
      end
      check("drain.empty", empty, 1);
      check("drain.count", count, 0);

      // Flush with a push pending, then a normal push, then reset mid-stream.
      apply(1, 0, 0, 8'h00, 3'd0, 0, 0, 2'd1);
      for (int i = 0; i < DEPTH; i++) push(8'hC0 + 8'(i), 3'd0);
      push(8'hEE, 3'd0);
      for (int i = 0; i < 8; i++) pop();
      check("pre_clr.count", count, 8);
      check("pre_clr.overrun", overrun, 1);
      apply(0, 1, 1, 8'h5A, 3'd0, 1, 0, 2'd1);
      check("clr.count", count, 0);
      check("clr.empty", empty, 1);
      check("clr.overrun", overrun, 1);
      check("clr.rd_valid", rd_valid, 0);
      check("clr.rd_data", rd_data, 8'hC7);
      push(8'h66, 3'd0);
      check("post_clr.count", count, 1);
      pop();
      check("post_clr.rd_data", rd_data, 8'h66);
      check("post_clr.empty", empty, 1);
      push(8'h01, 3'd5);
      push(8'h02, 3'd1);
      check("pre_rst.err_in_fifo", err_in_fifo, 1);
      apply(1, 1, 1, 8'hFF, 3'd7, 1, 1, 2'd0);
      check("rst.count", count, 0);
      check("rst.empty", empty, 1);
      check("rst.full", full, 0);
      check("rst.rd_valid", rd_valid, 0);
      check("rst.rd_data", rd_data, 0);
      check("rst.rd_err", rd_err, 0);
      check("rst.trig_hit", trig_hit, 0);
      check("rst.overrun", overrun, 0);
      check("rst.err_in_fifo", err_in_fifo, 0);

      // Randomized traffic against the queue model, alternating fill/drain bias.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic r, c, we, re, oc;
         logic [2:0] e;
         logic [1:0] t;
         hi_wr = ((cyc / 150) % 2) == 0;
         r  = ($urandom_range(0, 299) == 0);
         c  = ($urandom_range(0, 79) == 0);
         we = ($urandom_range(0, 99) < (hi_wr ? 75 : 35));
         re = ($urandom_range(0, 99) < (hi_wr ? 35 : 75));
         oc = ($urandom_range(0, 19) == 0);
         e  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         t  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : trig_lvl;
         apply(r, c, we, 8'($urandom), e, re, oc, t);
         check_model(cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised successor to the team's lite FIFO, used as the 16550 RX and TX data buffers. Each entry stores a data word and a per-entry error tag (parity/framing/break on RX; tie to zero on TX). Adds occupancy count, synchronous flush, a programmable trigger level, a sticky overrun flag and an error-in-FIFO flag. The UART core writes on one side, and the register block / line driver reads on the other, all in one clock domain.

## Interface
- WIDTH, 8, data bits per entry
- ERR_WIDTH, 3, error-tag bits per entry (use 1 for TX; tie `wr_err` to zero)
- DEPTH, 16, number of entries; power of two, ≥ 8
- ADDR_WIDTH (localparam), $clog2(DEPTH)
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous flush, equivalent to FCR RX/TX reset
- wr_en  in  1  push request
- wr_data  in  WIDTH  push data
- wr_err  in  ERR_WIDTH  push error tag
- rd_en  in  1  pop request
- rd_data  out  WIDTH  popped data, registered
- rd_err  out  ERR_WIDTH  popped error tag, registered
- rd_valid  out  1  one-cycle pulse: rd_data/rd_err updated
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- trig_lvl  in  2  00 = 1, 01 = DEPTH/4, 10 = DEPTH/2, 11 = DEPTH−2 (for DEPTH = 16 this gives 1/4/8/14)
- trig_hit  out  1  count ≥ selected threshold
- overrun  out  1  sticky: a push was dropped
- ovr_clr  in  1  clears overrun
- err_in_fifo  out  1  at least one stored entry has a non-zero tag (LSR bit 7)

## Operation
- Reset values: rd_data = 0, rd_err = 0, rd_valid = 0, count = 0, empty = 1, full = 0, trig_hit = 0, overrun = 0, err_in_fifo = 0. Pointers and the error counter are 0.
- Pop is accepted when rd_en && !empty.
  - rd_data/rd_err are loaded from rd_ptr and rd_ptr increments.
  - rd_valid = 1 on the next cycle.
  - rd_en while empty is ignored: rd_valid stays 0 and rd_data holds its value.
- Push is accepted when wr_en && (!full || pop accepted in the same cycle).
  - Entry is written at wr_ptr and wr_ptr increments.
- Full and write:
  - A push while full with no same-cycle pop is dropped; storage is unchanged and overrun is set.
  - A push while full with a same-cycle pop is accepted; count stays DEPTH.
- Simultaneous push and pop when empty: only the push is accepted; count becomes 1 and rd_valid stays 0 (no bypass).
- Pointers are ADDR_WIDTH bits and wrap naturally. count is tracked explicitly: +1, −1, or unchanged on simultaneous accept.
- err_in_fifo is driven by an error counter (width ADDR_WIDTH+1) of entries whose tag is non-zero.
  - Increment on an accepted push with a non-zero tag.
  - Decrement on an accepted pop of a non-zero entry.
  - Both in one cycle: unchanged.
  - err_in_fifo = (err_cnt != 0).
- clr has priority over push and pop in the same cycle. It zeroes pointers, count and err_cnt, and forces rd_valid to 0. It does not change rd_data, rd_err or overrun.
- ovr_clr clears overrun. If a drop and ovr_clr occur in the same cycle, the set wins.
- rst overrides everything, including clr, mid-operation.
- trig_hit is compared against the current trig_lvl every cycle, so a trig_lvl change takes effect on the next comparison.

## Timing
- All outputs are registered or decoded purely from registered state. There is no combinational path from any input to any output.
- Push to visible: count, empty, full and trig_hit reflect an accepted push on the cycle after the write edge.
- Pop latency: rd_en is sampled at edge N; rd_data and rd_valid are valid after edge N, for one cycle.
- Back-to-back pops: one per cycle, with rd_valid held high continuously.
- clr: after the edge, empty = 1 and count = 0. A push on the following cycle works normally.

## Structure
- Shared package `uart_pkg`:
  - typedef `trig_lvl_e` (TRIG_1, TRIG_Q, TRIG_H, TRIG_NF)
  - function `trig_threshold(trig_lvl_e, depth)` returning the count threshold
- Sub-module `fifo_mem`:
  - DEPTH × (WIDTH+ERR_WIDTH) simple dual-port storage
  - synchronous write, synchronous registered read
  - no reset on the array
- The top level holds pointers, counters, flags and handshake logic.

## Test plan
- Reset, then write 0x41..0x44 with zero tags → count = 4, trig_hit = 1 at TRIG_Q. Four pops return 0x41..0x44 with four consecutive rd_valid pulses, then empty = 1.
- Fill 16 entries, then a 17th push of 0x99 → full = 1, overrun = 1, entries unchanged. ovr_clr → overrun = 0. A same-cycle ovr_clr plus dropped push → overrun stays 1.
- With full, simultaneous push 0xAA and pop → count stays 16, the oldest entry pops, and 0xAA emerges last after wrap-around.
- Push 0x10 (tag 0), 0x20 (tag 3'b010), 0x30 (tag 0) → err_in_fifo = 1. After popping 0x20, err_in_fifo = 0 and rd_err = 3'b010 on that pop.
- Empty FIFO with simultaneous push and pop → count = 1 and no rd_valid. rd_en while empty → rd_data unchanged.
- 8 entries queued, then clr asserted with wr_en high → count = 0, empty = 1, the push is discarded, and overrun is unchanged. rst mid-stream → all reset values restored.
